// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared 64-bit ALU.
// Operands are registered on accept, the result is registered after the ALU.
module alu_share_arbiter #(
    parameter int   DATA_W     = 64,
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d, err_q, err_d;

    logic              gnt_any, gnt_id;
    logic [DATA_W-1:0] alu_res;
    logic              alu_err;

    // Pointer only breaks ties; a lone requester always wins.
    assign gnt_any = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;

    assign req0_ready = ~reset & (state_q == IDLE) & gnt_any & ~gnt_id;
    assign req1_ready = ~reset & (state_q == IDLE) & gnt_any &  gnt_id;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            4'd0:    alu_res = a_q & b_q;
            4'd1:    alu_res = a_q | b_q;
            4'd2:    alu_res = a_q + b_q;
            4'd6:    alu_res = a_q - b_q;
            4'd12:   alu_res = ~(a_q | b_q);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_d     = gnt_id ? req1_a  : req0_a;
                    b_d     = gnt_id ? req1_b  : req0_b;
                    op_d    = gnt_id ? req1_op : req0_op;
                    id_d    = gnt_id;
                    ptr_d   = ~gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                err_d   = alu_err;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PRIO_RESET;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and responses,
// a negedge monitor compares handshake signals and pops expected responses.
module tb_alu_share_arbiter;

    localparam logic PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [63:0] rsp_result;

    alu_share_arbiter #(.DATA_W(64), .PRIO_RESET(PRIO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: one operation in flight at most, counted in cycles since accept.
    bit   m_started = 0;
    bit   m_after_reset = 0;
    bit   m_inflight = 0;
    int   m_age = 0;
    logic m_ptr = PRIO;

    function automatic exp_t ref_op(logic id, logic [63:0] a, logic [63:0] b, logic [3:0] op);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            4'd0:    e.res = a & b;
            4'd1:    e.res = a | b;
            4'd2:    e.res = a + b;
            4'd6:    e.res = a - b;
            4'd12:   e.res = ~(a | b);
            default: begin e.res = 64'd0; e.err = 1'b1; end
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_inflight    = 0;
            m_age         = 0;
            m_ptr         = PRIO;
            m_after_reset = 1;
            m_started     = 1;
            exp_q.delete();
        end else begin
            m_after_reset = 0;
            if (m_inflight) begin
                if (m_age >= 1 && rsp_ready) m_inflight = 0;
                else m_age = 1;
            end else if (req0_valid || req1_valid) begin
                logic g;
                g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                if (g) exp_q.push_back(ref_op(1'b1, req1_a, req1_b, req1_op));
                else   exp_q.push_back(ref_op(1'b0, req0_a, req0_b, req0_op));
                m_ptr      = ~g;
                m_inflight = 1;
                m_age      = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic er0, er1;
            er0 = !reset && !m_inflight && req0_valid && (!req1_valid || !m_ptr);
            er1 = !reset && !m_inflight && req1_valid && (!req0_valid ||  m_ptr);
            chk("req0_ready", {63'd0, req0_ready}, {63'd0, er0});
            chk("req1_ready", {63'd0, req1_ready}, {63'd0, er1});
            chk("busy", {63'd0, busy}, {63'd0, m_inflight});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, (m_inflight && m_age >= 1)});
            if (m_after_reset) begin
                chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
                chk("reset_rsp_result", rsp_result, 64'd0);
                chk("reset_rsp_zero", {63'd0, rsp_zero}, 64'd0);
                chk("reset_rsp_err", {63'd0, rsp_err}, 64'd0);
            end
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got response id=%0d result=%h expected none at %0t",
                             rsp_id, rsp_result, $time);
                end else begin
                    chk("rsp_id", {63'd0, rsp_id}, {63'd0, exp_q[0].id});
                    chk("rsp_result", rsp_result, exp_q[0].res);
                    chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, exp_q[0].zero});
                    chk("rsp_err", {63'd0, rsp_err}, {63'd0, exp_q[0].err});
                    if (rsp_ready && !reset) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic solo0(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        step(3);
        req0_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(3))
            0:       return 64'd0;
            1:       return '1;
            2:       return {$urandom, $urandom};
            default: return 64'($urandom_range(15));
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        case ($urandom_range(5))
            0:       return 4'd0;
            1:       return 4'd1;
            2:       return 4'd2;
            3:       return 4'd6;
            4:       return 4'd12;
            default: return 4'($urandom_range(15));
        endcase
    endfunction

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        step(3);
        reset = 1'b0;
        step(1);

        // Lone req1: 5 - 3
        req1_valid = 1'b1; req1_a = 64'd5; req1_b = 64'd3; req1_op = 4'd6;
        step(1);
        req1_valid = 1'b0;
        step(4);

        // Both continuously valid: strict alternation
        req0_valid = 1'b1; req0_a = 64'd1;    req0_b = 64'd1;    req0_op = 4'd2;
        req1_valid = 1'b1; req1_a = 64'hF0;   req1_b = 64'h0F;   req1_op = 4'd0;
        step(12);

        // Consumer stalls in RESP
        rsp_ready = 1'b0;
        step(8);
        rsp_ready = 1'b1;
        step(6);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(4);

        // Wrap-around, NOR, illegal then legal
        solo0('1, 64'd1, 4'd2);
        solo0(64'd0, 64'd1, 4'd6);
        solo0(64'd0, 64'd0, 4'd12);
        solo0(64'h1234, 64'h55, 4'd7);
        solo0(64'h8, 64'h1, 4'd1);
        step(2);

        // Reset while in EXEC abandons the op and restores the pointer
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd4; req1_op = 4'd2;
        step(1);
        req1_valid = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd7; req0_op = 4'd6;
        req1_valid = 1'b1; req1_a = 64'd2; req1_b = 64'd1; req1_op = 4'd1;
        step(7);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(4);

        // Random traffic, back-pressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(99) < 60);
            req1_valid = ($urandom_range(99) < 60);
            req0_a = rand64(); req0_b = rand64(); req0_op = rand_op();
            req1_a = rand64(); req1_b = rand64(); req1_op = rand_op();
            rsp_ready  = ($urandom_range(99) < 70);
            reset      = ($urandom_range(99) < 2);
            step(1);
        end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step(5);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares a single 64-bit ALU datapath between two requesters (e.g. execute-stage port and address-generation port) using valid/ready handshakes.
- Uses round-robin arbitration and registers the operands before the ALU and the result after it.
- The ALU is instantiated internally. Supported op encodings: 0 AND, 1 OR, 2 ADD, 6 SUB, 12 NOR.
- Returns the result, zero flag, requester ID and an illegal-op error on a single response channel.

Parameters:
- DATA_W, 64, operand/result width; fixed at 64 to match the ALU datapath, other values unsupported.
- PRIO_RESET, 0, requester holding priority immediately after reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  64  requester 0 operand A.
- req0_b  input  64  requester 0 operand B.
- req0_op  input  4  requester 0 ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the operation.
- rsp_result  output  64  ALU result.
- rsp_zero  output  1  1 when rsp_result == 0.
- rsp_err  output  1  op code not in {0,1,2,6,12}.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, reset high at a clk edge):
  - state=IDLE, priority pointer=PRIO_RESET.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - req0_ready=0, req1_ready=0, busy=0.
  - Reset mid-operation abandons the operation; no response is produced for it.
- State machine has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant: the only valid requester, or the pointer's requester if both are valid.
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE, only when reset=0. It never depends on rsp_ready.
  - On the accept edge: latch a, b, op and id into internal registers; move pointer to the other requester (pointer = 1 - granted id); go to EXEC.
  - No valid requester: stay in IDLE, pointer unchanged.
- EXEC:
  - ALU operates on the latched operands only; later changes on the req inputs have no effect.
  - At the edge: register result, zero and err; go to RESP.
  - ADD/SUB wrap modulo 2^64; no carry or overflow output.
  - Illegal op: result=0, zero=1, err=1. There is no latched or stale value.
- RESP:
  - rsp_valid=1; rsp_* held stable until the handshake.
  - rsp_valid & rsp_ready at an edge: go to IDLE; rsp_valid drops next cycle.
  - No requests are accepted in EXEC or RESP: both readies stay 0.
  - After leaving RESP, rsp_* data keeps its last value (don't-care while rsp_valid=0).
- Latency and throughput:
  - Accept at edge N gives rsp_valid=1 in the cycle after edge N+1.
  - With rsp_ready held high the next accept is possible 3 cycles after the previous one, so throughput is 1 op per 3 cycles.
- Fairness:
  - Two continuously valid requesters alternate strictly.
  - A lone requester is served back-to-back regardless of the pointer.
- A requester dropping valid before being granted is legal; nothing is latched for it.
- Simultaneous reset with a handshake: reset wins, nothing is accepted.

Test Plan:
- Reset with PRIO_RESET=0, then req1 alone with a=5, b=3, op=6: req1_ready in IDLE cycle, then rsp_valid 2 cycles later with rsp_id=1, result=2, zero=0, err=0.
- Both valid continuously, req0 op=2 (1+1), req1 op=0 (0xF0 & 0x0F), rsp_ready=1: grants alternate 0,1,0,1. Responses in order: result 2 (id0), then 0 with zero=1 (id1), and so on.
- rsp_ready held low 5 cycles in RESP: rsp_valid and rsp_result stay stable, both readies stay 0, busy=1; after rsp_ready rises, IDLE follows and the next grant goes to the pending requester.
- Wrap-around: op=2 with a=0xFFFF_FFFF_FFFF_FFFF, b=1 gives result 0, zero=1; op=6 with a=0, b=1 gives result 0xFFFF_FFFF_FFFF_FFFF; op=12 with a=b=0 gives all ones.
- Illegal op=7 from req0: rsp_err=1, result=0, zero=1. A following legal op=1 (a=0x8, b=0x1) gives result 9, err=0.
- Reset asserted in EXEC: next cycle state is IDLE, rsp_valid=0, busy=0, pointer=PRIO_RESET, and no response is emitted for the aborted op.
